// File: rtl/alu_logic_pipe_if.sv
// rtl/alu_logic_pipe_if.sv - handshake and operand bundle for the pipelined logic unit
interface alu_logic_pipe_if #(
  parameter int W     = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   y;
  logic             err;
  logic             zero;
  logic [CNT_W-1:0] done_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, err, zero, done_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, err, zero, done_count
  );
endinterface

// File: rtl/alu_logic_pipe.sv
// rtl/alu_logic_pipe.sv - opcode-selected W-bit logic unit behind an elastic valid/ready pipeline
module alu_logic_pipe #(
  parameter int W      = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  alu_logic_pipe_if.slave bus
);

  logic [W-1:0]      r_in;
  logic              err_in;

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] e_q;
  logic [STAGES-1:0] z_q;
  logic [W-1:0]      r_q [STAGES];

  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_e;
  logic [STAGES-1:0] src_z;
  logic [W-1:0]      src_r [STAGES];

  logic [CNT_W-1:0]  cnt_q;
  logic              out_hs;

  // Logic function evaluated on the raw inputs as they enter stage 0.
  always_comb begin
    r_in   = '0;
    err_in = 1'b0;
    case (bus.op)
      3'd0: r_in = bus.a & bus.b;
      3'd1: r_in = bus.a | bus.b;
      3'd2: r_in = ~(bus.a & bus.b);
      3'd3: r_in = ~(bus.a | bus.b);
      3'd4: r_in = bus.a ^ bus.b;
      3'd5: r_in = ~(bus.a ^ bus.b);
      3'd6: r_in = ~bus.a;
      3'd7: begin
        r_in   = '0;
        err_in = 1'b1;
      end
      default: begin
        r_in   = '0;
        err_in = 1'b1;
      end
    endcase
  end

  assign src_v[0] = bus.in_valid;
  assign src_r[0] = r_in;
  assign src_e[0] = err_in;
  assign src_z[0] = (r_in == '0);

  // A stage may load when some stage at or after it is empty, or the tail is draining;
  // written in closed form so the ready chain has no combinational self-dependence.
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      assign load[k] = bus.out_ready || !(&v_q[STAGES-1:k]);
      if (k > 0) begin : g_link
        assign src_v[k] = v_q[k-1];
        assign src_r[k] = r_q[k-1];
        assign src_e[k] = e_q[k-1];
        assign src_z[k] = z_q[k-1];
      end
    end
  endgenerate

  // Stage registers: valid follows the source on load, payload only updates on a real
  // result so the output fields keep their last values once the pipe empties.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      e_q <= '0;
      z_q <= '0;
      for (int i = 0; i < STAGES; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          v_q[i] <= src_v[i];
          if (src_v[i]) begin
            r_q[i] <= src_r[i];
            e_q[i] <= src_e[i];
            z_q[i] <= src_z[i];
          end
        end
      end
    end
  end

  assign out_hs = v_q[STAGES-1] && bus.out_ready;

  // Saturating count of output handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (out_hs && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_ready   = load[0] && !reset;
  assign bus.out_valid  = v_q[STAGES-1];
  assign bus.y          = {{W{1'b0}}, r_q[STAGES-1]};
  assign bus.err        = e_q[STAGES-1];
  assign bus.zero       = z_q[STAGES-1];
  assign bus.done_count = cnt_q;

endmodule

// File: tb/tb_alu_logic_pipe.sv
// tb/tb_alu_logic_pipe.sv - scoreboard bench for alu_logic_pipe
module tb_alu_logic_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_logic_pipe_if #(.W(4), .CNT_W(16)) bus ();
  alu_logic_pipe_if #(.W(4), .CNT_W(4))  sbus ();

  alu_logic_pipe #(.W(4), .STAGES(2), .CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  alu_logic_pipe #(.W(4), .STAGES(2), .CNT_W(4)) dut_sat (
    .clk  (clk),
    .reset(reset),
    .bus  (sbus)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       err;
    logic       zero;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t sb[$];
  int   sat_hs = 0;
  logic stall_q = 1'b0;
  res_t stall_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input logic [3:0] r, input logic e);
    res_t t;
    t.y    = {4'h0, r};
    t.err  = e;
    t.zero = (r == 4'h0);
    return t;
  endfunction

  // Monitor: compares every output handshake with the head of the scoreboard and
  // checks that a stalled result stays put.
  always @(negedge clk) begin
    res_t cur;
    res_t exp;
    cur = '{y: bus.y, err: bus.err, zero: bus.zero};
    if (!reset) begin
      if (stall_q && bus.out_valid) check("hold_stable", 32'(cur), 32'(stall_v));
      stall_q = bus.out_valid && !bus.out_ready;
      stall_v = cur;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h expected none at %0t", cur, $time);
        end else begin
          exp = sb.pop_front();
          check("result", 32'(cur), 32'(exp));
        end
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && sbus.out_valid && sbus.out_ready) sat_hs++;
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input res_t e);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      check("send_timeout", 32'(n), 32'd0);
    end else begin
      sb.push_back(e);
      @(posedge clk);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] ytab [8];
    res_t       e;
    logic [3:0] av;
    logic [3:0] bv;

    ytab[0] = 8'h08; ytab[1] = 8'h0E; ytab[2] = 8'h07; ytab[3] = 8'h01;
    ytab[4] = 8'h06; ytab[5] = 8'h09; ytab[6] = 8'h03; ytab[7] = 8'h00;

    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.op         = '0;
    bus.out_ready  = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.a         = '0;
    sbus.b         = '0;
    sbus.op        = '0;
    sbus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd0);
    check("rst_done_count", 32'(bus.done_count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Latency: result visible in the second cycle after the input's cycle
    @(posedge clk);
    #1;
    send(4'hA, 4'h6, 3'd2, mk(4'hD, 1'b0));
    @(negedge clk);
    check("latency_cycle1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("latency_cycle2", 32'(bus.out_valid), 32'd1);
    check("latency_y", 32'(bus.y), 32'h0D);
    drain();

    // Exhaustive NAND sweep, back to back
    do_reset();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        av = 4'(i);
        bv = 4'(j);
        send(av, bv, 3'd2, mk(~(av & bv), 1'b0));
      end
    end
    drain();
    check("nand_done_count", 32'(bus.done_count), 32'd256);

    // Every opcode on a=C, b=A
    do_reset();
    for (int i = 0; i < 8; i++) begin
      e = '{y: ytab[i], err: (i == 7), zero: (i == 7)};
      send(4'hC, 4'hA, 3'(i), e);
    end
    drain();

    // Zero detect on a legal opcode
    send(4'hF, 4'hF, 3'd4, '{y: 8'h00, err: 1'b0, zero: 1'b1});
    drain();

    // Backpressure: two fill the pipe, third waits
    do_reset();
    bus.out_ready = 1'b0;
    send(4'h3, 4'h5, 3'd0, mk(4'h1, 1'b0));
    send(4'h3, 4'h5, 3'd1, mk(4'h7, 1'b0));
    bus.a        = 4'h3;
    bus.b        = 4'h5;
    bus.op       = 3'd4;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("held_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    sb.push_back(mk(4'h6, 1'b0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();
    check("bp_done_count", 32'(bus.done_count), 32'd3);

    // Reset with two results in flight and an input offered during reset
    bus.out_ready = 1'b0;
    send(4'h9, 4'h3, 3'd0, mk(4'h1, 1'b0));
    send(4'h9, 4'h3, 3'd1, mk(4'hB, 1'b0));
    reset = 1'b1;
    sb.delete();
    bus.out_ready = 1'b1;
    bus.a         = 4'h5;
    bus.b         = 4'h5;
    bus.op        = 3'd1;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_done_count", 32'(bus.done_count), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Saturation on the 4-bit counter instance
    @(posedge clk);
    #1;
    sbus.a        = 4'h1;
    sbus.b        = 4'h2;
    sbus.op       = 3'd1;
    sbus.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("sat_handshakes", 32'(sat_hs), 32'd20);
    check("sat_done_count", 32'(sbus.done_count), 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_logic_pipe.md
# alu_logic_pipe

Parametrised, pipelined bitwise logic unit for the ALU datapath. It generalises the fixed 4-bit NAND slice to a W-bit operand pair and an opcode-selected logic function. Each result is zero-extended to 2·W bits so it lines up with the arithmetic result bus. The block carries results through a STAGES-deep elastic pipeline with valid/ready handshakes on both sides, and keeps a saturating count of completed operations.

## Interface
- W, default 4: operand width in bits; must be ≥ 1.
- STAGES, default 2: pipeline depth in registers; must be ≥ 1.
- CNT_W, default 16: width of the completed-operation counter.

- clk  input  1  rising-edge clock, the only clock in the block.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and opcode are presented this cycle.
- in_ready  output  1  the block accepts the input this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- op  input  3  function select (see Operation).
- out_valid  output  1  result is presented this cycle.
- out_ready  input  1  the consumer accepts the result this cycle.
- y  output  2·W  result; y[2W-1:W] is always 0.
- err  output  1  qualified by out_valid; set when the result came from an illegal opcode.
- zero  output  1  qualified by out_valid; set when y == 0.
- done_count  output  CNT_W  number of output handshakes since reset; saturates.

## Operation
- Input handshake: in_valid && in_ready in the same cycle. Output handshake: out_valid && out_ready in the same cycle.
- The function is evaluated combinationally at stage 0 entry. Result bits r[W-1:0] by opcode:
  - 0: A&B
  - 1: A|B
  - 2: ~(A&B)
  - 3: ~(A|B)
  - 4: A^B
  - 5: ~(A^B)
  - 6: ~A, with b ignored
  - 7: illegal; r = 0 and err = 1
- y = {W'b0, r}. zero = (r == 0), including the illegal-opcode case.
- Each stage holds {valid, r, err}. Stage k loads from stage k-1 when stage k is empty, or when stage k is advancing in the same cycle.
- A stage that cannot advance holds its contents unchanged. Results are never dropped, duplicated or reordered.
- in_ready = !v[0] || stage 0 advancing. The last stage advances when out_ready is high. in_ready is combinational from out_ready through the ready chain.
- out_valid, y, err and zero are driven from the last stage registers.
- y, err and zero are held stable while out_valid is high and out_ready is low.
- done_count increments by 1 on each output handshake and stops at 2^CNT_W − 1.
- Reset mid-operation: every in-flight result is discarded and done_count returns to 0. During the reset cycle itself, nothing is accepted and no handshake is counted.

## Timing
- Reset values: all stage valids = 0, out_valid = 0, y = 0, err = 0, zero = 0, done_count = 0.
- in_ready = 1 in the first cycle after reset is released.
- Latency is STAGES cycles. An input accepted at edge n gives out_valid high after edge n+STAGES when nothing is stalled.
- Throughput is one result per cycle while out_ready is held high.
- Full condition: all STAGES stages valid and out_ready low. in_ready drops to 0 in that same cycle.
- When out_ready rises with the pipeline full, in_ready rises in the same cycle. A new input and an output handshake then complete on the same edge.
- Empty pipeline: out_valid = 0, and y/err/zero hold their last values.
- done_count updates on the edge of the handshake and is visible the following cycle.

## Test plan
- Exhaustive NAND (W=4, STAGES=2, out_ready=1): sweep a, b over 0..15 with op=2, all 256 pairs back to back.
  - Each y = {4'h0, ~(a&b)} arrives 2 cycles after its input, e.g. a=4'hA, b=4'h6 → y=8'h0D.
  - done_count ends at 256.
- All opcodes, a=4'hC, b=4'hA, op=0..7:
  - y = 08, 0E, 07, 01, 06, 09, 03, 00 respectively.
  - err = 1 only for op=7; zero = 1 only for op=7.
- Backpressure: out_ready=0 while issuing 3 transactions (STAGES=2).
  - in_ready goes 0 after 2 accepts, and the 3rd input is held.
  - After out_ready=1, results come out in order with no loss.
  - done_count = 3.
- Zero detect: a=4'hF, b=4'hF, op=4 → y=8'h00, zero=1, err=0.
- Reset mid-flight: assert reset for 1 cycle with 2 results in the pipeline.
  - The next cycle shows out_valid=0, done_count=0, in_ready=1, and no stale result ever appears.
- Saturation (CNT_W=4): complete 20 output handshakes → done_count stays at 15.
